alu_ctrl_muldiv: RTL and testbench
==================================

Name: alu_ctrl_muldiv

Overview:
- Parametrised next-generation ALU control and execute unit for the MIPS datapath.
- Decodes ALUOp/funct into the 4-bit ALU control code, extended to the full R-type arithmetic/logic set.
- Performs the single-cycle ALU operation.
- Adds an iterative multiply/divide engine with architectural HI/LO registers, a busy/stall handshake and MFHI/MFLO reads.
- Sits in the execute stage between register-file read and write-back.

Parameters:
- WIDTH, 32, datapath width in bits; must be ≥ 4 and even.
- CNT_W, 6, iteration counter width; must satisfy 2^CNT_W > WIDTH.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- in_valid  input  1  an instruction is presented this cycle.
- ALUOp  input  2  main-control ALU opcode.
- funct  input  6  R-type function field.
- src_a  input  WIDTH  operand A (rs).
- src_b  input  WIDTH  operand B (rt or immediate).
- alu_op_out  output  4  decoded ALU control code.
- result  output  WIDTH  ALU/MFHI/MFLO result, combinational.
- zero  output  1  result == 0.
- overflow  output  1  signed overflow on ADD/SUB.
- busy  output  1  mul/div engine iterating.
- stall  output  1  hold the pipeline; the instruction is not accepted.
- md_done  output  1  one-cycle pulse when HI/LO are updated.

Behaviour:

Decode (combinational)
- ALUOp 00 → ADD (0010); ALUOp 01 → SUB (0110); ALUOp 11 → SLT (0111).
- ALUOp 10 decodes funct:
  - 100000/100001 ADD/ADDU → 0010
  - 100010/100011 SUB/SUBU → 0110
  - 100100 AND → 0000
  - 100101 OR → 0001
  - 100110 XOR → 0011
  - 100111 NOR → 1100
  - 101010 SLT → 0111
  - 101011 SLTU → 0101
  - 011000 MULT, 011001 MULTU, 011010 DIV, 011011 DIVU → 1000
  - 010000 MFHI → 1001
  - 010010 MFLO → 1010
  - any other funct → 0000, with result forced to 0.
- ADD/SUB arithmetic is modulo 2^WIDTH.
- overflow is asserted only for funct ADD/SUB (signed) and ALUOp 00/01; it is 0 for ADDU/SUBU and all other ops.
- SLT/SLTU return {0…0, lt} using signed and unsigned compare respectively.
- MFHI/MFLO: result = HI / LO register value.
- Mul/div ops: result = 0.
- zero is computed from result in all cases.

Mul/div engine (sequential)
- States: IDLE, RUN.
- Issue: when state is IDLE, in_valid=1 and code=1000, the engine latches its inputs at edge E0 and enters RUN.
  - Latched: operand magnitudes (absolute values for signed ops), sign flags and the operation kind.
  - busy=1 from E0 until edge E0+WIDTH.
- Algorithms:
  - Multiply: radix-2 shift-add, one bit per cycle, WIDTH iterations.
  - Divide: restoring, one quotient bit per cycle, WIDTH iterations.
- Completion at edge E0+WIDTH:
  - Write HI/LO with sign fix-up applied.
  - Multiply: {HI, LO} = 2·WIDTH-bit product; negate it if the signs differ (MULT only).
  - Divide: LO = quotient, HI = remainder. Quotient is negated if the signs differ; remainder takes the dividend's sign (DIV only).
  - Return to IDLE. md_done=1 for exactly the following cycle; busy=0 during that cycle.
- Divide by zero:
  - Same latency.
  - LO = all ones, HI = src_a as latched (unmodified).
  - No error flag.
- Signed corner case: DIV of the most-negative value by −1 gives LO = most-negative value, HI = 0.

Stall and hazards
- stall = in_valid AND busy AND (code ∈ {1000, 1001, 1010}).
- While stall=1, the instruction is not issued or consumed; the upstream pipeline holds its inputs.
- Non-MD instructions (all other codes) execute normally while busy=1, with no stall.
- During the md_done cycle, busy=0: a new MUL/DIV may issue and MFHI/MFLO read the new values.
- Operand changes after issue do not affect the running operation.

Reset
- Reset forces IDLE, busy=0, md_done=0, HI=0, LO=0 and clears the counter, including when asserted mid-RUN; the partial result is discarded.
- Combinational outputs follow their inputs during reset.
- MFHI issued the cycle after reset returns 0.

Test Plan:
- ALUOp=10, funct=100000, src_a=0x7FFFFFFF, src_b=1 → result=0x80000000, overflow=1, alu_op_out=0010. Repeat with funct=100001 → overflow=0.
- funct=101010, a=0xFFFFFFFF, b=1 → result=1; funct=101011 with the same operands → result=0. NOR of a=0, b=0 → 0xFFFFFFFF, zero=0. Undefined funct=111111 → code 0000, result=0, zero=1.
- MULT a=−3 (0xFFFFFFFD), b=7 → busy high exactly 32 cycles, md_done pulses once, HI=0xFFFFFFFF, LO=0xFFFFFFEB. MULTU 0xFFFFFFFF × 0xFFFFFFFF → HI=0xFFFFFFFE, LO=0x00000001.
- DIV a=−7, b=2 → LO=0xFFFFFFFD, HI=0xFFFFFFFF. DIVU a=100, b=0 → LO=0xFFFFFFFF, HI=100.
- MFLO issued 5 cycles after a DIV → stall=1 until the md_done cycle, then result = new LO. An ADD issued during busy → no stall, correct sum.
- Reset asserted at cycle 10 of a MULT → next cycle busy=0, no md_done pulse, MFHI=0, MFLO=0.

Source files
------------

// File: rtl/alu_ctrl_muldiv.sv
// alu_ctrl_muldiv: execute-stage ALU control decode, single-cycle ALU, and an
// iterative multiply/divide engine that owns the architectural HI/LO registers.
// Ports:
//   clk, reset             rising-edge clock, synchronous active-high reset
//   in_valid               an instruction is presented this cycle
//   ALUOp, funct           main-control opcode and R-type function field
//   src_a, src_b           operands (rs, rt/immediate)
//   alu_op_out             decoded 4-bit ALU control code (combinational)
//   result, zero, overflow ALU/MFHI/MFLO result and flags (combinational)
//   busy                   mul/div engine iterating
//   stall                  hold the pipeline, instruction not accepted (combinational)
//   md_done                one-cycle pulse after HI/LO are written
module alu_ctrl_muldiv #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned CNT_W = 6
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    input  logic [1:0]       ALUOp,
    input  logic [5:0]       funct,
    input  logic [WIDTH-1:0] src_a,
    input  logic [WIDTH-1:0] src_b,
    output logic [3:0]       alu_op_out,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             overflow,
    output logic             busy,
    output logic             stall,
    output logic             md_done
);

    localparam int unsigned W2 = 2 * WIDTH;

    localparam logic [3:0] C_AND  = 4'b0000;
    localparam logic [3:0] C_OR   = 4'b0001;
    localparam logic [3:0] C_ADD  = 4'b0010;
    localparam logic [3:0] C_XOR  = 4'b0011;
    localparam logic [3:0] C_SLTU = 4'b0101;
    localparam logic [3:0] C_SUB  = 4'b0110;
    localparam logic [3:0] C_SLT  = 4'b0111;
    localparam logic [3:0] C_MD   = 4'b1000;
    localparam logic [3:0] C_MFHI = 4'b1001;
    localparam logic [3:0] C_MFLO = 4'b1010;
    localparam logic [3:0] C_NOR  = 4'b1100;

    typedef enum logic {S_IDLE, S_RUN} state_e;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [W2-1:0]      work_q, work_d;      // mul: {acc, multiplier}; div: {rem, quotient}
    logic [WIDTH-1:0]   opb_q, opb_d;        // multiplicand or divisor magnitude
    logic               is_div_q, is_div_d;
    logic               neg_q, neg_d;        // negate product / quotient
    logic               neg_rem_q, neg_rem_d; // remainder takes dividend sign
    logic               bzero_q, bzero_d;
    logic [WIDTH-1:0]   hi_q, hi_d, lo_q, lo_d;
    logic               md_done_q, md_done_d;

    // ALU control decode
    logic [3:0] code;
    logic       illegal;
    always_comb begin
        code    = C_AND;
        illegal = 1'b0;
        case (ALUOp)
            2'b00: code = C_ADD;
            2'b01: code = C_SUB;
            2'b11: code = C_SLT;
            default: begin
                case (funct)
                    6'b100000, 6'b100001: code = C_ADD;
                    6'b100010, 6'b100011: code = C_SUB;
                    6'b100100: code = C_AND;
                    6'b100101: code = C_OR;
                    6'b100110: code = C_XOR;
                    6'b100111: code = C_NOR;
                    6'b101010: code = C_SLT;
                    6'b101011: code = C_SLTU;
                    6'b011000, 6'b011001, 6'b011010, 6'b011011: code = C_MD;
                    6'b010000: code = C_MFHI;
                    6'b010010: code = C_MFLO;
                    default: illegal = 1'b1;
                endcase
            end
        endcase
    end

    // Single-cycle ALU
    logic [WIDTH-1:0] sum, diff;
    logic             add_signed, sub_signed, ovf_add, ovf_sub;
    assign sum  = src_a + src_b;
    assign diff = src_a - src_b;
    assign add_signed = (ALUOp == 2'b00) || (ALUOp == 2'b10 && funct == 6'b100000);
    assign sub_signed = (ALUOp == 2'b01) || (ALUOp == 2'b10 && funct == 6'b100010);
    assign ovf_add = (src_a[WIDTH-1] == src_b[WIDTH-1]) && (sum[WIDTH-1] != src_a[WIDTH-1]);
    assign ovf_sub = (src_a[WIDTH-1] != src_b[WIDTH-1]) && (diff[WIDTH-1] != src_a[WIDTH-1]);

    always_comb begin
        result = '0;
        case (code)
            C_AND:  result = src_a & src_b;
            C_OR:   result = src_a | src_b;
            C_ADD:  result = sum;
            C_XOR:  result = src_a ^ src_b;
            C_NOR:  result = ~(src_a | src_b);
            C_SUB:  result = diff;
            C_SLT:  result = WIDTH'($signed(src_a) < $signed(src_b));
            C_SLTU: result = WIDTH'(src_a < src_b);
            C_MFHI: result = hi_q;
            C_MFLO: result = lo_q;
            default: result = '0;
        endcase
        // unknown funct decodes to AND but must not produce a value
        if (illegal) begin
            result = '0;
        end
    end

    assign alu_op_out = code;
    assign zero       = (result == '0);
    assign overflow   = (add_signed && code == C_ADD && ovf_add) ||
                        (sub_signed && code == C_SUB && ovf_sub);

    // Engine operand preparation (funct[1]: divide, funct[0]: unsigned)
    logic             md_signed, a_neg, b_neg, md_issue;
    logic [WIDTH-1:0] a_mag, b_mag;
    assign md_signed = ~funct[0];
    assign a_neg     = md_signed & src_a[WIDTH-1];
    assign b_neg     = md_signed & src_b[WIDTH-1];
    assign a_mag     = a_neg ? (WIDTH'(0) - src_a) : src_a;
    assign b_mag     = b_neg ? (WIDTH'(0) - src_b) : src_b;
    assign md_issue  = in_valid && (state_q == S_IDLE) && (code == C_MD);

    // One shift-add or restoring-divide iteration
    logic [WIDTH:0]   mul_acc, div_r, div_diff;
    logic             div_ge;
    logic [W2-1:0]    mul_next, div_next, step, prod_fix;
    logic [WIDTH-1:0] quo, rem, quo_fix, rem_fix;
    always_comb begin
        mul_acc  = work_q[0] ? ({1'b0, work_q[W2-1:WIDTH]} + {1'b0, opb_q})
                             : {1'b0, work_q[W2-1:WIDTH]};
        mul_next = {mul_acc, work_q[WIDTH-1:1]};
        div_r    = {work_q[W2-1:WIDTH], work_q[WIDTH-1]};
        div_diff = div_r - {1'b0, opb_q};
        div_ge   = ~div_diff[WIDTH];
        div_next = {(div_ge ? div_diff[WIDTH-1:0] : div_r[WIDTH-1:0]),
                    work_q[WIDTH-2:0], div_ge};
        step     = is_div_q ? div_next : mul_next;
        prod_fix = neg_q ? (W2'(0) - step) : step;
        quo      = step[WIDTH-1:0];
        rem      = step[W2-1:WIDTH];
        quo_fix  = neg_q ? (WIDTH'(0) - quo) : quo;
        rem_fix  = neg_rem_q ? (WIDTH'(0) - rem) : rem;
    end

    // Engine next-state
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        work_d    = work_q;
        opb_d     = opb_q;
        is_div_d  = is_div_q;
        neg_d     = neg_q;
        neg_rem_d = neg_rem_q;
        bzero_d   = bzero_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        md_done_d = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (md_issue) begin
                    state_d   = S_RUN;
                    cnt_d     = '0;
                    work_d    = {WIDTH'(0), a_mag};
                    opb_d     = b_mag;
                    is_div_d  = funct[1];
                    neg_d     = a_neg ^ b_neg;
                    neg_rem_d = a_neg;
                    bzero_d   = (src_b == '0);
                end
            end
            default: begin
                work_d = step;
                cnt_d  = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(WIDTH - 1)) begin
                    state_d   = S_IDLE;
                    md_done_d = 1'b1;
                    if (!is_div_q) begin
                        {hi_d, lo_d} = prod_fix;
                    end else if (bzero_q) begin
                        // remainder magnitude is |a|; sign fix-up restores a itself
                        lo_d = '1;
                        hi_d = rem_fix;
                    end else begin
                        lo_d = quo_fix;
                        hi_d = rem_fix;
                    end
                end
            end
        endcase
    end

    // Engine state register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            work_q    <= '0;
            opb_q     <= '0;
            is_div_q  <= 1'b0;
            neg_q     <= 1'b0;
            neg_rem_q <= 1'b0;
            bzero_q   <= 1'b0;
            hi_q      <= '0;
            lo_q      <= '0;
            md_done_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            work_q    <= work_d;
            opb_q     <= opb_d;
            is_div_q  <= is_div_d;
            neg_q     <= neg_d;
            neg_rem_q <= neg_rem_d;
            bzero_q   <= bzero_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            md_done_q <= md_done_d;
        end
    end

    assign busy    = (state_q == S_RUN);
    assign md_done = md_done_q;
    assign stall   = in_valid && busy && (code == C_MD || code == C_MFHI || code == C_MFLO);

endmodule

// File: tb/tb_alu_ctrl_muldiv.sv
// tb_alu_ctrl_muldiv: directed self-checking bench for alu_ctrl_muldiv.
module tb_alu_ctrl_muldiv;

    localparam logic [5:0] F_ADD   = 6'b100000;
    localparam logic [5:0] F_ADDU  = 6'b100001;
    localparam logic [5:0] F_SUBU  = 6'b100011;
    localparam logic [5:0] F_AND   = 6'b100100;
    localparam logic [5:0] F_OR    = 6'b100101;
    localparam logic [5:0] F_XOR   = 6'b100110;
    localparam logic [5:0] F_NOR   = 6'b100111;
    localparam logic [5:0] F_SLT   = 6'b101010;
    localparam logic [5:0] F_SLTU  = 6'b101011;
    localparam logic [5:0] F_MULT  = 6'b011000;
    localparam logic [5:0] F_MULTU = 6'b011001;
    localparam logic [5:0] F_DIV   = 6'b011010;
    localparam logic [5:0] F_DIVU  = 6'b011011;
    localparam logic [5:0] F_MFHI  = 6'b010000;
    localparam logic [5:0] F_MFLO  = 6'b010010;
    localparam logic [5:0] F_BAD   = 6'b111111;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic [1:0]  ALUOp;
    logic [5:0]  funct;
    logic [31:0] src_a, src_b;
    logic [3:0]  alu_op_out;
    logic [31:0] result;
    logic        zero, overflow, busy, stall, md_done;

    int total = 0;
    int bad   = 0;
    int cyc, pulses, waits;

    alu_ctrl_muldiv #(.WIDTH(32), .CNT_W(6)) dut (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .ALUOp      (ALUOp),
        .funct      (funct),
        .src_a      (src_a),
        .src_b      (src_b),
        .alu_op_out (alu_op_out),
        .result     (result),
        .zero       (zero),
        .overflow   (overflow),
        .busy       (busy),
        .stall      (stall),
        .md_done    (md_done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [1:0] op, input logic [5:0] f,
                         input logic [31:0] a, input logic [31:0] b);
        in_valid = v;
        ALUOp    = op;
        funct    = f;
        src_a    = a;
        src_b    = b;
        #1;
    endtask

    task automatic idle();
        drive(1'b0, 2'b00, 6'd0, 32'd0, 32'd0);
    endtask

    // issue a mul/div and return once busy drops (the md_done cycle)
    task automatic md_run(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b,
                          output int n, output int p);
        drive(1'b1, 2'b10, f, a, b);
        step();
        idle();
        n = 0;
        p = 0;
        while (busy && n < 100) begin
            n++;
            if (md_done) p++;
            step();
        end
    endtask

    task automatic read_hilo(input string tag, input logic [31:0] hi, input logic [31:0] lo);
        drive(1'b1, 2'b10, F_MFHI, 32'd0, 32'd0);
        chk({tag, ".hi"}, result, hi);
        drive(1'b1, 2'b10, F_MFLO, 32'd0, 32'd0);
        chk({tag, ".lo"}, result, lo);
        idle();
    endtask

    task automatic md_case(input string tag, input logic [5:0] f, input logic [31:0] a,
                           input logic [31:0] b, input logic [31:0] hi, input logic [31:0] lo);
        md_run(f, a, b, cyc, pulses);
        chk({tag, ".busy_cycles"}, 32'(cyc), 32'd32);
        chk({tag, ".early_done"}, 32'(pulses), 32'd0);
        chk({tag, ".md_done"}, 32'(md_done), 32'd1);
        read_hilo(tag, hi, lo);
        step();
        chk({tag, ".done_once"}, 32'(md_done), 32'd0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        idle();
        step();
        step();
        chk("rst.busy", 32'(busy), 32'd0);
        chk("rst.md_done", 32'(md_done), 32'd0);
        reset = 1'b0;
        read_hilo("rst", 32'd0, 32'd0);

        // single-cycle ALU
        drive(1'b1, 2'b10, F_ADD, 32'h7FFFFFFF, 32'd1);
        chk("add.res", result, 32'h80000000);
        chk("add.ovf", 32'(overflow), 32'd1);
        chk("add.code", 32'(alu_op_out), 32'h2);
        drive(1'b1, 2'b10, F_ADDU, 32'h7FFFFFFF, 32'd1);
        chk("addu.res", result, 32'h80000000);
        chk("addu.ovf", 32'(overflow), 32'd0);
        drive(1'b1, 2'b01, 6'd0, 32'h80000000, 32'd1);
        chk("sub.res", result, 32'h7FFFFFFF);
        chk("sub.ovf", 32'(overflow), 32'd1);
        chk("sub.code", 32'(alu_op_out), 32'h6);
        drive(1'b1, 2'b10, F_SUBU, 32'h80000000, 32'd1);
        chk("subu.ovf", 32'(overflow), 32'd0);
        drive(1'b1, 2'b00, 6'd0, 32'h80000000, 32'h80000000);
        chk("lw_add.res", result, 32'd0);
        chk("lw_add.ovf", 32'(overflow), 32'd1);
        chk("lw_add.zero", 32'(zero), 32'd1);
        drive(1'b1, 2'b10, F_SLT, 32'hFFFFFFFF, 32'd1);
        chk("slt.res", result, 32'd1);
        chk("slt.code", 32'(alu_op_out), 32'h7);
        drive(1'b1, 2'b10, F_SLTU, 32'hFFFFFFFF, 32'd1);
        chk("sltu.res", result, 32'd0);
        chk("sltu.code", 32'(alu_op_out), 32'h5);
        chk("sltu.zero", 32'(zero), 32'd1);
        drive(1'b1, 2'b11, 6'd0, 32'd3, 32'd5);
        chk("aluop11.res", result, 32'd1);
        drive(1'b1, 2'b10, F_NOR, 32'd0, 32'd0);
        chk("nor.res", result, 32'hFFFFFFFF);
        chk("nor.zero", 32'(zero), 32'd0);
        chk("nor.code", 32'(alu_op_out), 32'hC);
        drive(1'b1, 2'b10, F_AND, 32'h0000F0F0, 32'h0000FF00);
        chk("and.res", result, 32'h0000F000);
        drive(1'b1, 2'b10, F_OR, 32'h0000F0F0, 32'h0000FF00);
        chk("or.res", result, 32'h0000FFF0);
        drive(1'b1, 2'b10, F_XOR, 32'h0000F0F0, 32'h0000FF00);
        chk("xor.res", result, 32'h00000FF0);
        chk("xor.code", 32'(alu_op_out), 32'h3);
        drive(1'b1, 2'b10, F_BAD, 32'd5, 32'd3);
        chk("bad.code", 32'(alu_op_out), 32'h0);
        chk("bad.res", result, 32'd0);
        chk("bad.zero", 32'(zero), 32'd1);
        drive(1'b0, 2'b10, F_MULT, 32'd9, 32'd9);
        chk("md.code", 32'(alu_op_out), 32'h8);
        chk("md.res", result, 32'd0);
        idle();
        step();
        chk("noissue.busy", 32'(busy), 32'd0);

        // mul/div engine
        md_case("mult", F_MULT, 32'hFFFFFFFD, 32'd7, 32'hFFFFFFFF, 32'hFFFFFFEB);
        md_case("multu", F_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001);
        md_case("div", F_DIV, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD);
        md_case("divu0", F_DIVU, 32'd100, 32'd0, 32'd100, 32'hFFFFFFFF);
        md_case("divmin", F_DIV, 32'h80000000, 32'hFFFFFFFF, 32'd0, 32'h80000000);
        md_case("divneg0", F_DIV, 32'hFFFFFFF9, 32'd0, 32'hFFFFFFF9, 32'hFFFFFFFF);

        // hazards: ADD during busy runs freely, MFLO stalls until the md_done cycle
        drive(1'b1, 2'b10, F_DIVU, 32'd100, 32'd7);
        step();
        idle();
        step();
        drive(1'b1, 2'b10, F_ADD, 32'd5, 32'd6);
        chk("haz.add.res", result, 32'd11);
        chk("haz.add.stall", 32'(stall), 32'd0);
        chk("haz.busy", 32'(busy), 32'd1);
        step();
        idle();
        step();
        step();
        step();
        drive(1'b1, 2'b10, F_MFLO, 32'd0, 32'd0);
        chk("haz.mflo.stall", 32'(stall), 32'd1);
        waits = 0;
        while (stall && waits < 100) begin
            step();
            waits++;
        end
        chk("haz.wait", 32'(waits), 32'd27);
        chk("haz.md_done", 32'(md_done), 32'd1);
        chk("haz.mflo.res", result, 32'd14);
        drive(1'b1, 2'b10, F_MFHI, 32'd0, 32'd0);
        chk("haz.mfhi.res", result, 32'd2);
        idle();
        step();

        // reset in the middle of a multiply discards it
        drive(1'b1, 2'b10, F_MULT, 32'd3, 32'd5);
        step();
        idle();
        repeat (9) step();
        chk("rstmid.busy_before", 32'(busy), 32'd1);
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk("rstmid.busy", 32'(busy), 32'd0);
        chk("rstmid.md_done", 32'(md_done), 32'd0);
        read_hilo("rstmid", 32'd0, 32'd0);
        step();
        chk("rstmid.no_done", 32'(md_done), 32'd0);
        chk("rstmid.idle", 32'(busy), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
